seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the 4-digit seven-segment display between two requesters, A and B. A typical pairing is a time/count value (A) and a status/message source (B).
- Sits directly upstream of the 4x7 segment controller and drives its Digit1..Digit4 and Dp0..Dp3 inputs.
- Alternating priority plus a minimum hold time, measured in prescaled ticks, prevents display flicker between sources.

Parameters:
- TICK_DIV, 24'd250000, SysClk cycles per hold tick (prescaler period); legal range 1..2^24-1.
- HOLD_TICKS, 8'd100, minimum ticks a granted source keeps the display before it can be pre-empted by the other source; legal range 1..255.

Ports:
- SysClk  input  1  system clock; all logic is rising-edge.
- Reset  input  1  synchronous, active-high reset.
- ReqA  input  1  requester A wants the display (level).
- DigitsA  input  16  A digits, [15:12]=Digit1 .. [3:0]=Digit4.
- DpA  input  4  A decimal points, [3]=Dp3 .. [0]=Dp0.
- ReqB  input  1  requester B wants the display (level).
- DigitsB  input  16  B digits, same packing as DigitsA.
- DpB  input  4  B decimal points, same packing as DpA.
- GntA  output  1  A owns the display.
- GntB  output  1  B owns the display.
- Digit1, Digit2, Digit3, Digit4  output  4 each  digit values to the segment controller.
- Dp0, Dp1, Dp2, Dp3  output  1 each  decimal points to the segment controller.
- Tick  output  1  one-cycle prescaler pulse, exported for test.

Behaviour:
- Reset (synchronous, active-high, at SysClk edge with Reset=1) drives:
  - state=IDLE, GntA=GntB=0
  - all Digit outputs=4'h0, all Dp outputs=0
  - prescaler=0, hold_cnt=0
  - last-served pointer=B, so A wins the first tie.
  - Reset mid-grant aborts the grant; outputs take their reset values on that same edge.
- Prescaler:
  - Free-running 24-bit counter, 0..TICK_DIV-1, wraps to 0.
  - Tick=1 for exactly the cycle in which the count equals TICK_DIV-1.
  - Grant changes do not restart the prescaler.
- States: IDLE, SERVE_A, SERVE_B.
  - GntA=1 exactly when state=SERVE_A; GntB=1 exactly when state=SERVE_B. The two grants are never both 1.
- IDLE transitions, evaluated each edge:
  - ReqA only -> SERVE_A.
  - ReqB only -> SERVE_B.
  - Both requesting -> the source not last served.
  - Neither requesting -> stay in IDLE.
- SERVE_X transitions (X = current owner, Y = the other source), evaluated each edge:
  - ReqX=0 and ReqY=1 -> SERVE_Y immediately; the hold time is ignored.
  - ReqX=0 and ReqY=0 -> IDLE.
  - ReqX=1, ReqY=1 and hold_cnt==HOLD_TICKS -> SERVE_Y.
  - Otherwise stay in SERVE_X.
- Last-served pointer: updated to X on every entry into SERVE_X.
- Hold counter (8 bits):
  - Cleared to 0 on any edge where the state changes.
  - While in SERVE_A/SERVE_B, increments on each Tick and saturates at HOLD_TICKS.
  - Held at 0 in IDLE.
- Display outputs (registered):
  - Every edge, Digit1..4 and Dp0..3 load from the source selected by the next state.
  - Outputs therefore change on the same edge as the matching grant, and track live DigitsX/DpX changes with 1-cycle latency while granted.
  - Next state IDLE -> Digits=4'h0, Dp=0.
- Latency: request assertion to grant/data is 1 edge when the arbiter is free.
- Simultaneous events:
  - A Tick on the same edge as a state change is discarded (the clear wins).
  - A request dropping on the same edge that hold expires follows the ReqX=0 rules.

Test Plan (TICK_DIV=4, HOLD_TICKS=3):
1. Reset held 2 cycles, then ReqA=ReqB=0 -> GntA=GntB=0, Digit1..4=0, Dp=0; Tick pulses every 4th cycle.
2. ReqA=1 with DigitsA=16'h1234, DpA=4'b0100 -> next edge: GntA=1, Digit1=1, Digit2=2, Digit3=3, Digit4=4, Dp2=1. Change DigitsA to 16'h5678 -> outputs show 5678 one edge later.
3. ReqA=ReqB=1 asserted together from IDLE after reset -> GntA=1 first. After the 3rd subsequent Tick (hold_cnt=3), the next edge gives GntB=1 and outputs show DigitsB. Keep both requesting -> ownership alternates every ~3 ticks.
4. While GntA=1 with hold_cnt=1 and ReqB=1, drop ReqA -> next edge GntB=1 (hold ignored). Then drop ReqB -> IDLE, Digits=0.
5. Hold expired but ReqB=0 -> A keeps the grant indefinitely and hold_cnt stays saturated at 3. Raise ReqB -> switch on the next edge.
6. Assert Reset for 1 cycle while GntB=1 -> on that edge GntB=0 and outputs=0. Then ReqA=ReqB=1 -> A wins (pointer reset to B).

Source files
------------

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//
// Shares one 4-digit seven-segment display between two requesters, A and B,
// and drives the Digit1..Digit4 / Dp0..Dp3 inputs of the downstream 4x7
// segment controller.
//
// Arbitration:
//   - From IDLE, a lone requester wins. If both request, the source that was
//     not served last wins. After reset the pointer says "B", so A wins the
//     first tie.
//   - The owner keeps the display while it requests. It is pre-empted by the
//     other source only when both request and the owner has held the display
//     for HOLD_TICKS prescaler ticks.
//   - If the owner drops its request, the display goes straight to the other
//     source when that source requests (no hold). Otherwise it goes to IDLE.
//   - The display outputs are registered and loaded from the source selected
//     by the next state. Data and grant therefore change on the same edge.
//
// Parameters:
//   TICK_DIV    SysClk cycles per hold tick (1 .. 2^24-1)
//   HOLD_TICKS  minimum ticks before pre-emption (1 .. 255)
//
// Ports:
//   SysClk                  system clock, rising edge
//   Reset                   synchronous active-high reset
//   ReqA / ReqB             level requests
//   DigitsA / DigitsB       [15:12]=Digit1 .. [3:0]=Digit4
//   DpA / DpB               [3]=Dp3 .. [0]=Dp0
//   GntA / GntB             current owner (never both 1)
//   Digit1..Digit4, Dp0..Dp3  registered display data to the segment controller
//   Tick                    one-cycle prescaler pulse
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
    parameter logic [23:0] TICK_DIV   = 24'd250000,
    parameter logic [7:0]  HOLD_TICKS = 8'd100
) (
    input  logic        SysClk,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic [15:0] DigitsA,
    input  logic [3:0]  DpA,
    input  logic        ReqB,
    input  logic [15:0] DigitsB,
    input  logic [3:0]  DpB,
    output logic        GntA,
    output logic        GntB,
    output logic [3:0]  Digit1,
    output logic [3:0]  Digit2,
    output logic [3:0]  Digit3,
    output logic [3:0]  Digit4,
    output logic        Dp0,
    output logic        Dp1,
    output logic        Dp2,
    output logic        Dp3,
    output logic        Tick
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_A = 2'd1,
        ST_SERVE_B = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_presc;
    logic [7:0]  r_hold_cnt;
    logic        r_last_a;      // 1: A was served last, 0: B was served last
    logic [15:0] r_digits;
    logic [3:0]  r_dp;

    logic        w_tick;
    logic        w_hold_done;
    logic        w_state_change;
    logic        w_sel_a;
    logic        w_sel_b;
    logic [15:0] w_digits_next;
    logic [3:0]  w_dp_next;

    // ------------------------------------------------------------------
    // Prescaler. It runs freely and grant changes never restart it.
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == (TICK_DIV - 24'd1));

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_presc <= 24'd0;
        end else if (w_tick) begin
            r_presc <= 24'd0;
        end else begin
            r_presc <= r_presc + 24'd1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign w_hold_done = (r_hold_cnt == HOLD_TICKS);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ReqA && ReqB) begin
                    w_state_next = r_last_a ? ST_SERVE_B : ST_SERVE_A;
                end else if (ReqA) begin
                    w_state_next = ST_SERVE_A;
                end else if (ReqB) begin
                    w_state_next = ST_SERVE_B;
                end
            end
            ST_SERVE_A: begin
                // A dropped request: hand over at once or release.
                if (!ReqA) begin
                    w_state_next = ReqB ? ST_SERVE_B : ST_IDLE;
                end else if (ReqB && w_hold_done) begin
                    w_state_next = ST_SERVE_B;
                end
            end
            ST_SERVE_B: begin
                if (!ReqB) begin
                    w_state_next = ReqA ? ST_SERVE_A : ST_IDLE;
                end else if (ReqA && w_hold_done) begin
                    w_state_next = ST_SERVE_A;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_state_change = (w_state_next != r_state);

    // ------------------------------------------------------------------
    // State, last-served pointer and hold counter
    // ------------------------------------------------------------------
    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_last_a   <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state <= w_state_next;

            if (w_state_change && (w_state_next == ST_SERVE_A)) begin
                r_last_a <= 1'b1;
            end else if (w_state_change && (w_state_next == ST_SERVE_B)) begin
                r_last_a <= 1'b0;
            end

            // A tick that coincides with a state change is dropped.
            if (w_state_change || (r_state == ST_IDLE)) begin
                r_hold_cnt <= 8'd0;
            end else if (w_tick && !w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display data. It is loaded from the next owner, so it moves together
    // with the grant.
    // ------------------------------------------------------------------
    assign w_sel_a = (w_state_next == ST_SERVE_A);
    assign w_sel_b = (w_state_next == ST_SERVE_B);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit_mux
            assign w_digits_next[gi*4 +: 4] = w_sel_a ? DigitsA[gi*4 +: 4] :
                                              w_sel_b ? DigitsB[gi*4 +: 4] : 4'h0;
            assign w_dp_next[gi]            = w_sel_a ? DpA[gi] :
                                              w_sel_b ? DpB[gi] : 1'b0;
        end
    endgenerate

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_digits <= 16'h0000;
            r_dp     <= 4'b0000;
        end else begin
            r_digits <= w_digits_next;
            r_dp     <= w_dp_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign GntA   = (r_state == ST_SERVE_A);
    assign GntB   = (r_state == ST_SERVE_B);
    assign Digit1 = r_digits[15:12];
    assign Digit2 = r_digits[11:8];
    assign Digit3 = r_digits[7:4];
    assign Digit4 = r_digits[3:0];
    assign Dp0    = r_dp[0];
    assign Dp1    = r_dp[1];
    assign Dp2    = r_dp[2];
    assign Dp3    = r_dp[3];
    assign Tick   = w_tick;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
//
// Table of per-edge vectors with hand-derived expected grants and display data
// for TICK_DIV=4, HOLD_TICKS=3. Expected Tick is derived from the number of
// edges since the last reset. Expectations are queued when the stimulus is
// driven and checked after the edge. A final hand-written sequence measures the
// pre-emption latency with a bounded wait.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

    localparam logic [15:0] DA1 = 16'h1234;
    localparam logic [15:0] DA2 = 16'h5678;
    localparam logic [15:0] DB  = 16'h9ABC;
    localparam logic [3:0]  PA  = 4'b0100;
    localparam logic [3:0]  PB  = 4'b0011;

    logic        SysClk = 1'b0;
    logic        Reset  = 1'b1;
    logic        ReqA   = 1'b0;
    logic        ReqB   = 1'b0;
    logic [15:0] DigitsA = 16'h0;
    logic [15:0] DigitsB = 16'h0;
    logic [3:0]  DpA = 4'h0;
    logic [3:0]  DpB = 4'h0;
    logic        GntA, GntB, Tick;
    logic [3:0]  Digit1, Digit2, Digit3, Digit4;
    logic        Dp0, Dp1, Dp2, Dp3;

    seg_display_arbiter #(
        .TICK_DIV   (24'd4),
        .HOLD_TICKS (8'd3)
    ) dut (
        .SysClk  (SysClk),
        .Reset   (Reset),
        .ReqA    (ReqA),
        .DigitsA (DigitsA),
        .DpA     (DpA),
        .ReqB    (ReqB),
        .DigitsB (DigitsB),
        .DpB     (DpB),
        .GntA    (GntA),
        .GntB    (GntB),
        .Digit1  (Digit1),
        .Digit2  (Digit2),
        .Digit3  (Digit3),
        .Digit4  (Digit4),
        .Dp0     (Dp0),
        .Dp1     (Dp1),
        .Dp2     (Dp2),
        .Dp3     (Dp3),
        .Tick    (Tick)
    );

    always #5 SysClk = ~SysClk;

    typedef struct {
        logic        rst;
        logic        ra;
        logic        rb;
        logic [15:0] da;
        logic [3:0]  pa;
        logic [15:0] db;
        logic [3:0]  pb;
        logic        ga;
        logic        gb;
        logic [15:0] dig;
        logic [3:0]  dp;
    } vec_t;

    typedef struct {
        int          idx;
        logic        ga;
        logic        gb;
        logic [15:0] dig;
        logic [3:0]  dp;
        logic        tick;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edges_since_rst = 0;

    function automatic void add(input int n, input logic rst, input logic ra, input logic rb,
                                input logic [15:0] da, input logic [3:0] pa,
                                input logic ga, input logic gb,
                                input logic [15:0] dig, input logic [3:0] dp);
        vec_t v;
        v.rst = rst; v.ra = ra; v.rb = rb;
        v.da = da; v.pa = pa; v.db = DB; v.pb = PB;
        v.ga = ga; v.gb = gb; v.dig = dig; v.dp = dp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge SysClk);
        Reset = v.rst; ReqA = v.ra; ReqB = v.rb;
        DigitsA = v.da; DpA = v.pa; DigitsB = v.db; DpB = v.pb;
        if (v.rst) edges_since_rst = 0;
        else       edges_since_rst++;
        e.idx = idx; e.ga = v.ga; e.gb = v.gb; e.dig = v.dig; e.dp = v.dp;
        e.tick = v.rst ? 1'b0 : ((edges_since_rst % 4) == 3);
        sb.push_back(e);
        @(posedge SysClk);
        #1;
        got.ga = GntA; got.gb = GntB;
        got.dig = {Digit1, Digit2, Digit3, Digit4};
        got.dp = {Dp3, Dp2, Dp1, Dp0};
        got.tick = Tick;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            if (got.ga !== e.ga || got.gb !== e.gb || got.dig !== e.dig ||
                got.dp !== e.dp || got.tick !== e.tick) begin
                n_err++;
                $display("FAIL vec%0d: got gA=%0b gB=%0b dig=%h dp=%b tick=%0b, want gA=%0b gB=%0b dig=%h dp=%b tick=%0b",
                         e.idx, got.ga, got.gb, got.dig, got.dp, got.tick,
                         e.ga, e.gb, e.dig, e.dp, e.tick);
            end else begin
                $display("vec%0d ok: rst=%0b reqA=%0b reqB=%0b gA=%0b gB=%0b dig=%h dp=%b tick=%0b",
                         e.idx, v.rst, v.ra, v.rb, got.ga, got.gb, got.dig, got.dp, got.tick);
            end
        end
    endtask

    initial begin
        int wait_edges;
        bit seen;

        // Reset and idle; Tick on every 4th edge.
        add(2,  1, 0, 0, DA1, PA, 0, 0, 16'h0, 4'h0);
        add(3,  0, 0, 0, DA1, PA, 0, 0, 16'h0, 4'h0);    // E1..E3
        // A requests alone; the tick on this edge is dropped by the clear.
        add(1,  0, 1, 0, DA1, PA, 1, 0, DA1, PA);        // E4
        add(1,  0, 1, 0, DA2, PA, 1, 0, DA2, PA);        // E5: live data
        // Both request: ticks at E8, E12, E16 -> hold=3, switch at E17.
        add(11, 0, 1, 1, DA2, PA, 1, 0, DA2, PA);        // E6..E16
        add(12, 0, 1, 1, DA2, PA, 0, 1, DB,  PB);        // E17..E28
        add(4,  0, 1, 1, DA2, PA, 1, 0, DA2, PA);        // E29..E32, hold=1
        // A drops with hold=1: hand over immediately, then release.
        add(1,  0, 0, 1, DA2, PA, 0, 1, DB,  PB);        // E33
        add(1,  0, 0, 0, DA2, PA, 0, 0, 16'h0, 4'h0);    // E34
        // A alone past expiry; hold saturates, then B pre-empts at once.
        add(16, 0, 1, 0, DA2, PA, 1, 0, DA2, PA);        // E35..E50
        add(2,  0, 1, 1, DA2, PA, 0, 1, DB,  PB);        // E51..E52
        // Reset mid-grant, then tie goes to A.
        add(1,  1, 1, 1, DA2, PA, 0, 0, 16'h0, 4'h0);
        add(2,  0, 1, 1, DA2, PA, 1, 0, DA2, PA);
        add(1,  0, 0, 1, DA2, PA, 0, 1, DB,  PB);
        add(1,  0, 0, 0, DA2, PA, 0, 0, 16'h0, 4'h0);
        add(1,  0, 1, 1, DA2, PA, 1, 0, DA2, PA);        // last served B -> A
        add(1,  0, 0, 0, DA2, PA, 0, 0, 16'h0, 4'h0);
        add(1,  0, 1, 1, DA2, PA, 0, 1, DB,  PB);        // last served A -> B

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Pre-emption latency: reset, A granted, then B joins.
        add(0, 0, 0, 0, DA2, PA, 0, 0, 16'h0, 4'h0);
        begin
            vec_t v;
            v = vecs[0];
            step(v, 900);
            v.rst = 0; v.ra = 1; v.rb = 0; v.da = DA2; v.pa = PA;
            v.ga = 1; v.gb = 0; v.dig = DA2; v.dp = PA;
            step(v, 901);
        end
        @(negedge SysClk);
        ReqB = 1'b1;
        seen = 1'b0;
        wait_edges = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge SysClk);
            #1;
            if (GntB) begin
                seen = 1'b1;
                wait_edges = i;
            end
        end
        n_vec++;
        if (!seen || wait_edges != 12) begin
            n_err++;
            $display("FAIL preempt_latency: got %0d edges (seen=%0b), want 12", wait_edges, seen);
        end else begin
            $display("preempt_latency ok: %0d edges", wait_edges);
        end
        n_vec++;
        if ({Digit1, Digit2, Digit3, Digit4} !== DB || {Dp3, Dp2, Dp1, Dp0} !== PB) begin
            n_err++;
            $display("FAIL preempt_data: got dig=%h dp=%b, want dig=%h dp=%b",
                     {Digit1, Digit2, Digit3, Digit4}, {Dp3, Dp2, Dp1, Dp0}, DB, PB);
        end else begin
            $display("preempt_data ok: dig=%h dp=%b", DB, PB);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
